// File: rtl/bus_window_stats_if.sv
// Handshake/bus bundle for bus_window_stats: sample input side plus the
// registered window-result output with its valid/ready pair.
interface bus_window_stats_if #(
    parameter int DATA_W  = 6,
    parameter int WIN_LEN = 8
);
    localparam int SUM_W = DATA_W + $clog2(WIN_LEN) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [7:0]        out_count;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_max;
    logic [7:0]        drop_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_sum, out_count, out_min, out_max, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_sum, out_count, out_min, out_max, drop_cnt
    );
endinterface

// File: rtl/bus_window_stats.sv
// Fixed-length window statistics (sum/count, optional min/max) over the sample
// stream; undeliverable windows are dropped and counted. Min/max: STATS_MINMAX_EN.
module bus_window_stats #(
    parameter int DATA_W  = 6,
    parameter int WIN_LEN = 8
) (
    input logic              clk,
    input logic              rst,
    bus_window_stats_if.slave bus
);
    localparam int SUM_W = DATA_W + $clog2(WIN_LEN) + 1;

    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [7:0]       acc_cnt_q, acc_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [7:0]       out_count_q, out_count_d;
    logic [7:0]       drop_q, drop_d;

    logic [SUM_W-1:0] win_sum;
    logic [7:0]       win_cnt;
    logic             close;
    logic             deliver;

    always_comb begin
        win_sum = acc_sum_q + (bus.in_valid ? SUM_W'(bus.in_data) : '0);
        win_cnt = acc_cnt_q + 8'(bus.in_valid);
        // The WIN_LEN-th sample and a simultaneous flush close only one window.
        close   = (bus.in_valid && (acc_cnt_q == 8'(WIN_LEN - 1)))
                || (bus.flush && ((acc_cnt_q != '0) || bus.in_valid));
        deliver = !out_valid_q || bus.out_ready;

        acc_sum_d   = close ? '0 : win_sum;
        acc_cnt_d   = close ? '0 : win_cnt;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        drop_d      = drop_q;

        if (close) begin
            if (deliver) begin
                out_valid_d = 1'b1;
                out_sum_d   = win_sum;
                out_count_d = win_cnt;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum_q   <= '0;
            acc_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            drop_q      <= '0;
        end else begin
            acc_sum_q   <= acc_sum_d;
            acc_cnt_q   <= acc_cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.drop_cnt  = drop_q;

`ifdef STATS_MINMAX_EN
    logic [DATA_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [DATA_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;
    logic [DATA_W-1:0] win_min, win_max;

    always_comb begin
        win_min = run_min_q;
        win_max = run_max_q;
        if (bus.in_valid) begin
            if (bus.in_data < run_min_q) win_min = bus.in_data;
            if (bus.in_data > run_max_q) win_max = bus.in_data;
        end
        run_min_d = close ? '1 : win_min;
        run_max_d = close ? '0 : win_max;
        out_min_d = (close && deliver) ? win_min : out_min_q;
        out_max_d = (close && deliver) ? win_max : out_max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_min_q <= '1;
            run_max_q <= '0;
            out_min_q <= '0;
            out_max_q <= '0;
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            out_min_q <= out_min_d;
            out_max_q <= out_max_d;
        end
    end

    assign bus.out_min = out_min_q;
    assign bus.out_max = out_max_q;
`else
    assign bus.out_min = '0;
    assign bus.out_max = '0;
`endif
endmodule

// File: tb/tb_bus_window_stats.sv
// Bench for bus_window_stats: fixed vector table, directed corner sequences and
// randomized traffic, all checked against a window-queue reference model.
module tb_bus_window_stats;
    localparam int DATA_W  = 6;
    localparam int WIN_LEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_window_stats_if #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN)) bus ();

    bus_window_stats #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the open window is a plain list of samples.
    int win[$];
    int m_valid, m_sum, m_cnt, m_min, m_max, m_drop;

    task automatic model_step(input bit v, input int d, input bit f, input bit r);
        int s, mn, mx;
        if (rst) begin
            win.delete();
            m_valid = 0; m_sum = 0; m_cnt = 0; m_min = 0; m_max = 0; m_drop = 0;
            return;
        end
        if (v) win.push_back(d);
        if ((v && win.size() == WIN_LEN) || (f && win.size() > 0)) begin
            if (m_valid == 0 || r) begin
                s = 0; mn = (1 << DATA_W) - 1; mx = 0;
                foreach (win[k]) begin
                    s += win[k];
                    if (win[k] < mn) mn = win[k];
                    if (win[k] > mx) mx = win[k];
                end
                m_valid = 1;
                m_sum   = s;
                m_cnt   = win.size();
`ifdef STATS_MINMAX_EN
                m_min = mn;
                m_max = mx;
`else
                m_min = 0;
                m_max = 0;
`endif
            end else if (m_drop < 255) begin
                m_drop++;
            end
            win.delete();
        end else if (m_valid == 1 && r) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock: drive at negedge, advance model, sample 1 time unit after posedge.
    task automatic cycle(input bit v, input int d, input bit f, input bit r);
        bus.in_valid  = v;
        bus.in_data   = DATA_W'(d);
        bus.flush     = f;
        bus.out_ready = r;
        model_step(v, d, f, r);
        @(posedge clk);
        #1;
        chk("model_valid", 32'(bus.out_valid), m_valid);
        chk("model_sum",   32'(bus.out_sum),   m_sum);
        chk("model_count", 32'(bus.out_count), m_cnt);
        chk("model_min",   32'(bus.out_min),   m_min);
        chk("model_max",   32'(bus.out_max),   m_max);
        chk("model_drop",  32'(bus.drop_cnt),  m_drop);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v; int d; bit f; bit r;
        int ev; int es; int ec; int emin; int emax; int ed;
    } vec_t;

    vec_t tbl[24];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, i, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1'b1, 7,  1'b0, 1'b1, 1, 28, 8, 0, 7, 0};
        tbl[8]  = '{1'b0, 0,  1'b0, 1'b1, 0, 28, 8, 0, 7, 0};
        tbl[9]  = '{1'b1, 10, 1'b0, 1'b1, 0, 28, 8, 0, 7, 0};
        tbl[10] = '{1'b1, 20, 1'b0, 1'b1, 0, 28, 8, 0, 7, 0};
        tbl[11] = '{1'b1, 30, 1'b0, 1'b1, 0, 28, 8, 0, 7, 0};
        tbl[12] = '{1'b0, 0,  1'b1, 1'b1, 1, 60, 3, 10, 30, 0};
        tbl[13] = '{1'b0, 0,  1'b0, 1'b1, 0, 60, 3, 10, 30, 0};
        tbl[14] = '{1'b0, 0,  1'b1, 1'b1, 0, 60, 3, 10, 30, 0};
        tbl[15] = '{1'b0, 0,  1'b0, 1'b1, 0, 60, 3, 10, 30, 0};
        for (int i = 16; i < 23; i++) tbl[i] = '{1'b1, 63, 1'b0, 1'b1, 0, 60, 3, 10, 30, 0};
        tbl[23] = '{1'b1, 63, 1'b0, 1'b1, 1, 504, 8, 63, 63, 0};

        @(negedge clk);
        do_reset();
        chk("reset_valid", 32'(bus.out_valid), 0);
        chk("reset_sum",   32'(bus.out_sum),   0);
        chk("reset_count", 32'(bus.out_count), 0);
        chk("reset_min",   32'(bus.out_min),   0);
        chk("reset_max",   32'(bus.out_max),   0);
        chk("reset_drop",  32'(bus.drop_cnt),  0);

        for (int i = 0; i < 24; i++) begin
            int emin, emax;
            cycle(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
`ifdef STATS_MINMAX_EN
            emin = tbl[i].emin;
            emax = tbl[i].emax;
`else
            emin = 0;
            emax = 0;
`endif
            chk("tbl_valid", 32'(bus.out_valid), tbl[i].ev);
            chk("tbl_sum",   32'(bus.out_sum),   tbl[i].es);
            chk("tbl_count", 32'(bus.out_count), tbl[i].ec);
            chk("tbl_min",   32'(bus.out_min),   emin);
            chk("tbl_max",   32'(bus.out_max),   emax);
            chk("tbl_drop",  32'(bus.drop_cnt),  tbl[i].ed);
        end

        // Drop and saturation with the consumer stalled.
        do_reset();
        for (int i = 0; i < 24; i++) cycle(1'b1, i, 1'b0, 1'b0);
        chk("drop_held_valid", 32'(bus.out_valid), 1);
        chk("drop_held_sum",   32'(bus.out_sum),   28);
        chk("drop_two",        32'(bus.drop_cnt),  2);
        for (int i = 0; i < 258 * WIN_LEN; i++) cycle(1'b1, int'($urandom_range(0, 63)), 1'b0, 1'b0);
        chk("drop_sat",        32'(bus.drop_cnt),  255);
        chk("drop_sat_sum",    32'(bus.out_sum),   28);

        // New window closes in the same cycle the pending result is accepted.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 5, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 9, 1'b0, 1'b0);
        chk("cda_pending_sum", 32'(bus.out_sum), 40);
        cycle(1'b1, 9, 1'b0, 1'b1);
        chk("cda_valid", 32'(bus.out_valid), 1);
        chk("cda_sum",   32'(bus.out_sum),   72);
        chk("cda_drop",  32'(bus.drop_cnt),  0);

        // Reset in the middle of a window.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 50, 1'b0, 1'b1);
        do_reset();
        chk("rmw_valid", 32'(bus.out_valid), 0);
        for (int i = 1; i <= 8; i++) cycle(1'b1, i, 1'b0, 1'b1);
        chk("rmw_valid2", 32'(bus.out_valid), 1);
        chk("rmw_sum",    32'(bus.out_sum),   36);
        chk("rmw_count",  32'(bus.out_count), 8);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_window_stats.md
# bus_window_stats

Downstream consumer of the 6-bit bus-breakout result stream. Collects one sample per valid cycle into fixed-length windows and reports each window's sum, sample count and, optionally, min/max through a registered valid/ready output. The input never back-pressures because the upstream stage has no stall. A completed window that cannot be delivered is dropped and counted.

## Interface
- DATA_W, 6, sample width.
- WIN_LEN, 8, samples per window; legal range 2..255.
- SUM_W, derived: DATA_W + $clog2(WIN_LEN) + 1. Not overridable. Default value is 10.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  sample present this cycle.
- in_data  in  DATA_W  sample, unsigned.
- flush  in  1  single-cycle pulse; closes the current window early.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  SUM_W  sum of the window's samples.
- out_count  out  8  number of samples in the window (1..WIN_LEN).
- out_min  out  DATA_W  smallest sample in the window.
- out_max  out  DATA_W  largest sample in the window.
- drop_cnt  out  8  windows lost; saturates at 255.

## Operation
- **Accumulator registers:** acc_sum, acc_cnt, run_min and run_max.
  - Idle values: acc_sum=0, acc_cnt=0, run_min=all-ones, run_max=0.
- **Accepting a sample:** every in_valid cycle accepts a sample and updates all four accumulator registers.
- **Window close:** a window closes on either of:
  - accepting the WIN_LEN-th sample;
  - flush=1 while the window is non-empty, counting a sample accepted in the same cycle.
- **Flush special cases:**
  - flush with acc_cnt=0 and in_valid=0 is ignored.
  - flush on the cycle that also accepts the WIN_LEN-th sample closes a single window.
- **After a close:** the accumulator returns to idle values on the next cycle, and the next sample starts a new window.
- **Delivering the closed window:** it loads the output register if out_valid=0, or if out_valid=1 and out_ready=1 in the same cycle.
  - In the second case out_valid stays 1 and the new result replaces the old one. There is no bubble.
- **Dropping the closed window:** otherwise the window is discarded and drop_cnt increments, saturating at 255. The held result is unchanged.
- **Output handshake:** out_valid=1 with out_ready=1 and no new close drives out_valid to 0.
  - out_sum, out_count, out_min and out_max hold their last values while out_valid=0.
  - They are stable while out_valid=1 and out_ready=0.
- **Arithmetic:** unsigned throughout. SUM_W covers WIN_LEN×(2^DATA_W−1) with one guard bit, so no overflow is possible.

## Timing
- **Reset values:** out_valid=0, out_sum=0, out_count=0, out_min=0, out_max=0, drop_cnt=0, accumulator idle.
- **rst mid-window:** the partial window is discarded and no result is emitted.
- **rst with a pending result:** the result is lost and does not count as a drop.
- **Latency:** the result appears the cycle after the closing sample or flush.
- **Back-to-back windows:** full throughput; a sample on every cycle is accepted continuously.
- **out_ready while out_valid=0:** ignored.

## Configuration
- **STATS_MINMAX_EN defined:** run_min and run_max are built, and out_min/out_max report as specified above.
- **STATS_MINMAX_EN undefined:** no min/max registers or comparators are instantiated. out_min and out_max are tied to 0. All other behaviour is identical.

## Test plan
- **Single window:** WIN_LEN=8, out_ready=1, in_data 0..7 on consecutive cycles.
  - Response: one cycle after sample 7, out_valid=1 with out_sum=28, out_count=8, min=0, max=7. With STATS_MINMAX_EN undefined, min=max=0.
- **Full-scale window:** eight samples of 63. Response: out_sum=504, out_count=8, min=max=63.
- **Drop and saturation:**
  - Stimulus: out_ready=0, then 24 consecutive samples.
  - Required: the first window is held unchanged, drop_cnt=2.
  - Continue until 260 windows have been lost: drop_cnt=255.
- **Flush behaviour:**
  - Samples 10, 20, 30, then flush with in_valid=0 → out_sum=60, out_count=3, min=10, max=30.
  - Flush with an empty window → no output.
- **Close during accept:**
  - Stimulus: result pending, out_ready=1 on the same cycle a new window closes.
  - Required: out_valid stays 1, new values load, drop_cnt is unchanged.
- **Reset mid-window:**
  - Stimulus: 5 samples, then rst, then samples 1..8.
  - Required: out_sum=36, out_count=8. No result from the partial window.
